// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder
// Packs symbolic LEGv8 instruction requests (op select, register fields,
// immediate) into 32-bit machine words in R, I, D, CB or B format and writes
// them to instruction memory at consecutive word addresses, one word per
// accept/ack handshake pair.
//
// Build option: define ENC_NOP_PAD_EN to fill every address after an
// acknowledged HALT (up to MAX_ADDR) with 32'h00000000 before reporting done.
module legv8_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_STEP = 4,
    parameter int MAX_ADDR  = 252
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [25:0]       imm,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic [7:0]        err_count,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [3:0] {
        OP_LDUR = 4'd0,
        OP_STUR = 4'd1,
        OP_ADD  = 4'd2,
        OP_ADDI = 4'd3,
        OP_SUB  = 4'd4,
        OP_AND  = 4'd5,
        OP_ORR  = 4'd6,
        OP_CBZ  = 4'd7,
        OP_CBNZ = 4'd8,
        OP_B    = 4'd9,
        OP_HALT = 4'd10
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
`ifdef ENC_NOP_PAD_EN
        S_PAD,
`endif
        S_DONE
    } state_e;

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [31:0] HALT_WORD = {11'h7FF, 21'd0};

    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_ADDR);

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              halt_q, halt_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              enc_halt;

    // A signed immediate fits a narrower field when every bit above the
    // field's sign bit repeats that sign bit.
    logic d_fits, cb_fits, addi_fits;
    assign d_fits    = (imm[25:8]  == '0) || (imm[25:8]  == '1);
    assign cb_fits   = (imm[25:18] == '0) || (imm[25:18] == '1);
    assign addi_fits = (imm[25:12] == '0);

    // Encode the current request and decide whether it is legal.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        enc_halt  = 1'b0;
        case (op_sel)
            OP_LDUR: begin
                enc_word  = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
                enc_legal = d_fits;
            end
            OP_STUR: begin
                enc_word  = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
                enc_legal = d_fits;
            end
            OP_ADD: begin
                enc_word  = {OPC_ADD, rm, 6'd0, rn, rd};
                enc_legal = 1'b1;
            end
            OP_ADDI: begin
                enc_word  = {OPC_ADDI, imm[11:0], rn, rd};
                enc_legal = addi_fits;
            end
            OP_SUB: begin
                enc_word  = {OPC_SUB, rm, 6'd0, rn, rd};
                enc_legal = 1'b1;
            end
            OP_AND: begin
                enc_word  = {OPC_AND, rm, 6'd0, rn, rd};
                enc_legal = 1'b1;
            end
            OP_ORR: begin
                enc_word  = {OPC_ORR, rm, 6'd0, rn, rd};
                enc_legal = 1'b1;
            end
            OP_CBZ: begin
                enc_word  = {OPC_CBZ, imm[18:0], rd};
                enc_legal = cb_fits;
            end
            OP_CBNZ: begin
                enc_word  = {OPC_CBNZ, imm[18:0], rd};
                enc_legal = cb_fits;
            end
            OP_B: begin
                enc_word  = {OPC_B, imm};
                enc_legal = 1'b1;
            end
            OP_HALT: begin
                enc_word  = HALT_WORD;
                enc_legal = 1'b1;
                enc_halt  = 1'b1;
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic for the accept/write handshake.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        halt_d      = halt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_ACCEPT;
                    mem_addr_d  = ADDR_BASE;
                    done_d      = 1'b0;
                    overflow_d  = 1'b0;
                    err_count_d = '0;
                end
            end
            S_ACCEPT: begin
                if (in_valid && in_ready_q) begin
                    if (enc_legal) begin
                        mem_wdata_d = enc_word;
                        halt_d      = enc_halt;
                        mem_we_d    = 1'b1;
                        state_d     = S_WRITE;
                    end else begin
                        err_d = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    mem_we_d = 1'b0;
                    if (halt_q) begin
`ifdef ENC_NOP_PAD_EN
                        if (mem_addr_q == ADDR_LAST) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            mem_addr_d  = mem_addr_q + ADDR_INC;
                            mem_wdata_d = '0;
                            mem_we_d    = 1'b1;
                            state_d     = S_PAD;
                        end
`else
                        done_d  = 1'b1;
                        state_d = S_DONE;
`endif
                    end else if (mem_addr_q == ADDR_LAST) begin
                        overflow_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_INC;
                        state_d    = S_ACCEPT;
                    end
                end
            end
`ifdef ENC_NOP_PAD_EN
            S_PAD: begin
                if (mem_ack) begin
                    if (mem_addr_q == ADDR_LAST) begin
                        mem_we_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_INC;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready is registered so it is high exactly while the FSM sits in ACCEPT.
    assign in_ready_d = (state_d == S_ACCEPT);

    // State and output registers with synchronous reset.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_BASE;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            halt_q      <= halt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Testbench for legv8_instr_encoder: instance 0 uses default parameters,
// instance 1 uses MAX_ADDR = 8 for the memory-full case. A reference model
// predicts every memory write; a compare process checks each write cycle.
module tb_legv8_instr_encoder;

    localparam int MAX0 = 252;
    localparam int MAX1 = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v [2];
    logic        in_valid;
    logic [3:0]  op_sel;
    logic [4:0]  rd, rn, rm;
    logic [25:0] imm;
    logic        ack_v [2];
    logic        rdy_v [2];
    logic        we_v [2];
    logic        err_v [2];
    logic        done_v [2];
    logic        ovf_v [2];
    logic [7:0]  addr_v [2];
    logic [7:0]  cnt_v [2];
    logic [31:0] data_v [2];

    always #5 clk = ~clk;

    legv8_instr_encoder u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .in_valid(in_valid),
        .in_ready(rdy_v[0]), .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
        .mem_we(we_v[0]), .mem_ack(ack_v[0]), .mem_addr(addr_v[0]),
        .mem_wdata(data_v[0]), .err(err_v[0]), .err_count(cnt_v[0]),
        .done(done_v[0]), .overflow(ovf_v[0])
    );

    legv8_instr_encoder #(.MAX_ADDR(MAX1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .in_valid(in_valid),
        .in_ready(rdy_v[1]), .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
        .mem_we(we_v[1]), .mem_ack(ack_v[1]), .mem_addr(addr_v[1]),
        .mem_wdata(data_v[1]), .err(err_v[1]), .err_count(cnt_v[1]),
        .done(done_v[1]), .overflow(ovf_v[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [39:0] q0[$];
    logic [39:0] q1[$];
    int next_addr [2];
    bit exp_done [2];
    bit exp_ovf [2];
    int ack_delay [2];
    int wait_cnt [2];

    function automatic int max_of(input int t);
        return (t == 0) ? MAX0 : MAX1;
    endfunction

    function automatic int q_size(input int t);
        return (t == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [39:0] q_front(input int t);
        return (t == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int t);
        if (t == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic q_push(input int t, input int a, input logic [31:0] w);
        if (t == 0) q0.push_back({8'(a), w});
        else        q1.push_back({8'(a), w});
    endtask

    function automatic bit model_legal(input int op, input int v);
        case (op)
            3:       return (v >= 0) && (v <= 4095);
            0, 1:    return (v >= -256) && (v <= 255);
            7, 8:    return (v >= -(1 << 18)) && (v < (1 << 18));
            default: return (op >= 0) && (op <= 10);
        endcase
    endfunction

    function automatic logic [31:0] model_word(input int op, input int d, input int n,
                                               input int m, input int v);
        logic [31:0] u, r, rr, rk;
        u  = 32'(v);
        r  = 32'(d);
        rr = 32'(n) << 5;
        rk = 32'(m) << 16;
        case (op)
            0:  return (32'h7C2 << 21) | ((u & 32'h1FF) << 12) | rr | r;
            1:  return (32'h7C0 << 21) | ((u & 32'h1FF) << 12) | rr | r;
            2:  return (32'h458 << 21) | rk | rr | r;
            3:  return (32'h244 << 22) | ((u & 32'hFFF) << 10) | rr | r;
            4:  return (32'h658 << 21) | rk | rr | r;
            5:  return (32'h450 << 21) | rk | rr | r;
            6:  return (32'h550 << 21) | rk | rr | r;
            7:  return (32'hB4 << 24) | ((u & 32'h7FFFF) << 5) | r;
            8:  return (32'hB5 << 24) | ((u & 32'h7FFFF) << 5) | r;
            9:  return (32'h5 << 26) | (u & 32'h3FFFFFF);
            10: return 32'hFFE00000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_accept(input int t, input logic [31:0] w, input bit halt);
        q_push(t, next_addr[t], w);
        if (halt) begin
`ifdef ENC_NOP_PAD_EN
            for (int a = next_addr[t] + 4; a <= max_of(t); a += 4) q_push(t, a, 32'h0);
`endif
            exp_done[t] = 1'b1;
        end else if (next_addr[t] == max_of(t)) begin
            exp_ovf[t]  = 1'b1;
            exp_done[t] = 1'b1;
        end else begin
            next_addr[t] += 4;
        end
    endtask

    // ---------------- memory responder + write compare ----------------
    task automatic cmp_step(input int t);
        logic [39:0] f;
        if (reset) begin
            ack_v[t]    = 1'b0;
            wait_cnt[t] = 0;
        end else if (we_v[t]) begin
            if (q_size(t) == 0) begin
                check($sformatf("unexpected_write%0d", t), 32'(we_v[t]), 32'h0);
                ack_v[t] = 1'b0;
            end else begin
                f = q_front(t);
                check($sformatf("wr_addr%0d", t), 32'(addr_v[t]), 32'(f[39:32]));
                check($sformatf("wr_data%0d", t), data_v[t], f[31:0]);
                if (wait_cnt[t] >= ack_delay[t]) begin
                    ack_v[t]    = 1'b1;
                    wait_cnt[t] = 0;
                    q_pop(t);
                end else begin
                    ack_v[t] = 1'b0;
                    wait_cnt[t]++;
                end
            end
        end else begin
            ack_v[t]    = 1'b0;
            wait_cnt[t] = 0;
        end
    endtask

    initial begin
        ack_v[0] = 1'b0;
        ack_v[1] = 1'b0;
        forever begin
            @(negedge clk);
            cmp_step(0);
            cmp_step(1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q0.delete();
        q1.delete();
        for (int t = 0; t < 2; t++) begin
            next_addr[t] = 0;
            exp_done[t]  = 1'b0;
            exp_ovf[t]   = 1'b0;
            wait_cnt[t]  = 0;
        end
    endtask

    task automatic do_start(input int t);
        start_v[t] = 1'b1;
        @(negedge clk);
        start_v[t]   = 1'b0;
        next_addr[t] = 0;
        exp_done[t]  = 1'b0;
        exp_ovf[t]   = 1'b0;
    endtask

    task automatic send(input int t, input int op, input int d, input int n, input int m,
                        input int v, input int budget, output bit acc, output bit err_seen);
        op_sel   = 4'(op);
        rd       = 5'(d);
        rn       = 5'(n);
        rm       = 5'(m);
        imm      = 26'(v);
        in_valid = 1'b1;
        acc      = 1'b0;
        err_seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rdy_v[t]) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (acc) begin
            if (model_legal(op, v)) model_accept(t, model_word(op, d, n, m, v), op == 10);
            @(negedge clk);
            err_seen = err_v[t];
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int t, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q_size(t) == 0 && !we_v[t]) return;
            @(negedge clk);
        end
        check($sformatf("drain_timeout%0d", t), 32'(q_size(t)), 32'h0);
    endtask

    typedef struct { int op; int v; } bnd_t;

    // ---------------- main sequence ----------------
    initial begin
        bit   acc, es;
        bnd_t bnd [13];

        reset      = 1'b1;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        in_valid   = 1'b0;
        op_sel     = '0;
        rd = '0; rn = '0; rm = '0; imm = '0;
        ack_delay[0] = 0;
        ack_delay[1] = 0;
        repeat (3) @(negedge clk);
        do_reset();

        // Reset state of both instances.
        for (int t = 0; t < 2; t++) begin
            check("rst_in_ready", 32'(rdy_v[t]), 32'h0);
            check("rst_mem_we",   32'(we_v[t]),  32'h0);
            check("rst_err",      32'(err_v[t]), 32'h0);
            check("rst_done",     32'(done_v[t]), 32'h0);
            check("rst_overflow", 32'(ovf_v[t]), 32'h0);
            check("rst_mem_addr", 32'(addr_v[t]), 32'h0);
            check("rst_wdata",    data_v[t], 32'h0);
            check("rst_err_count", 32'(cnt_v[t]), 32'h0);
        end

        // Hand-computed words pin the model.
        check("pin_add",  model_word(2, 1, 2, 3, 0),  32'h8B030041);
        check("pin_ldur", model_word(0, 5, 6, 0, -8), 32'hF85F80C5);
        check("pin_stur", model_word(1, 5, 6, 0, 16), 32'hF80100C5);
        check("pin_cbz",  model_word(7, 9, 0, 0, -2), 32'hB4FFFFC9);
        check("pin_b",    model_word(9, 0, 0, 0, 3),  32'h14000003);
        check("pin_halt", model_word(10, 0, 0, 0, 0), 32'hFFE00000);

        // ADD with immediate ack; address advances to 4.
        do_start(0);
        check("start_in_ready", 32'(rdy_v[0]), 32'h1);
        send(0, 2, 1, 2, 3, 0, 10, acc, es);
        check("add_accepted", 32'(acc), 32'h1);
        wait_idle(0, 20);
        check("add_next_addr", 32'(addr_v[0]), 32'h4);

        // start while in ACCEPT is ignored.
        do_start(0);
        next_addr[0] = 4;
        check("start_ignored_addr", 32'(addr_v[0]), 32'h4);
        check("start_ignored_rdy",  32'(rdy_v[0]), 32'h1);

        // LDUR / STUR at a fresh program.
        do_reset();
        do_start(0);
        send(0, 0, 5, 6, 0, -8, 10, acc, es);
        send(0, 1, 5, 6, 0, 16, 10, acc, es);
        wait_idle(0, 20);
        check("ldst_next_addr", 32'(addr_v[0]), 32'h8);

        // Rejected requests: err pulse, count, no write, still ready.
        send(0, 3, 1, 1, 0, 5000, 10, acc, es);
        check("addi_big_err",   32'(es), 32'h1);
        check("addi_big_ready", 32'(rdy_v[0]), 32'h1);
        send(0, 13, 1, 1, 1, 0, 10, acc, es);
        check("op13_err",   32'(es), 32'h1);
        check("op13_ready", 32'(rdy_v[0]), 32'h1);
        @(negedge clk);
        check("err_is_pulse",  32'(err_v[0]), 32'h0);
        check("err_count_two", 32'(cnt_v[0]), 32'h2);
        check("no_write_after_err", 32'(we_v[0]), 32'h0);

        // Immediate range boundaries and remaining R-type ops.
        bnd[0]  = '{3, 4095};       bnd[1]  = '{3, 4096};
        bnd[2]  = '{0, -256};       bnd[3]  = '{0, 256};
        bnd[4]  = '{1, 255};        bnd[5]  = '{1, -257};
        bnd[6]  = '{8, -(1 << 18)}; bnd[7]  = '{7, 1 << 18};
        bnd[8]  = '{7, (1 << 18) - 1};
        bnd[9]  = '{4, 0};          bnd[10] = '{5, 0};
        bnd[11] = '{6, 0};          bnd[12] = '{9, -1};
        for (int i = 0; i < 13; i++) begin
            send(0, bnd[i].op, 7, 8, 9, bnd[i].v, 10, acc, es);
            check($sformatf("bnd%0d_err", i), 32'(es), 32'(!model_legal(bnd[i].op, bnd[i].v)));
            wait_idle(0, 20);
        end

        // err_count saturates at 255.
        for (int i = 0; i < 256; i++) send(0, 15, 0, 0, 0, 0, 10, acc, es);
        check("err_count_sat", 32'(cnt_v[0]), 32'hFF);

        // HALT ends the program; start from DONE clears status.
        send(0, 10, 0, 0, 0, 0, 10, acc, es);
        wait_idle(0, 400);
        check("halt_done", 32'(done_v[0]), 32'h1);
        check("halt_ovf",  32'(ovf_v[0]), 32'h0);
        do_start(0);
        check("restart_done",  32'(done_v[0]), 32'h0);
        check("restart_count", 32'(cnt_v[0]), 32'h0);
        check("restart_addr",  32'(addr_v[0]), 32'h0);

        // CBZ, B, HALT with acks delayed three cycles.
        ack_delay[0] = 3;
        send(0, 7, 9, 0, 0, -2, 20, acc, es);
        send(0, 9, 0, 0, 0, 3, 20, acc, es);
        send(0, 10, 0, 0, 0, 0, 20, acc, es);
        wait_idle(0, 2000);
        check("cb_done",      32'(done_v[0]), 32'(exp_done[0]));
        check("cb_done_lit",  32'(done_v[0]), 32'h1);
        check("cb_ovf",       32'(ovf_v[0]), 32'h0);
        check("cb_not_ready", 32'(rdy_v[0]), 32'h0);

        // Reset while a write is pending drops mem_we.
        do_reset();
        do_start(0);
        ack_delay[0] = 1000;
        send(0, 2, 3, 3, 3, 0, 10, acc, es);
        check("pending_we", 32'(we_v[0]), 32'h1);
        do_reset();
        check("rst_mid_we",   32'(we_v[0]), 32'h0);
        check("rst_mid_addr", 32'(addr_v[0]), 32'h0);
        ack_delay[0] = 0;

        // Small memory: three writes fill it, fourth request never accepted.
        do_start(1);
        for (int i = 0; i < 3; i++) send(1, 2, i, i + 1, i + 2, 0, 10, acc, es);
        wait_idle(1, 20);
        send(1, 2, 4, 4, 4, 0, 10, acc, es);
        check("full_fourth_rejected", 32'(acc), 32'h0);
        check("full_overflow", 32'(ovf_v[1]), 32'h1);
        check("full_done",     32'(done_v[1]), 32'h1);
        check("full_addr",     32'(addr_v[1]), 32'h8);

`ifdef ENC_NOP_PAD_EN
        // HALT at address 0 pads zeros up to the last address.
        do_reset();
        do_start(1);
        send(1, 10, 0, 0, 0, 0, 10, acc, es);
        wait_idle(1, 50);
        check("pad_done", 32'(done_v[1]), 32'h1);
        check("pad_ovf",  32'(ovf_v[1]), 32'h0);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/legv8_instr_encoder.md
Name: legv8_instr_encoder

Overview:
- Turns symbolic instruction requests (op select, register fields, immediate) into 32-bit LEGv8 machine words.
- Packs each request into the R, I, D, CB or B format and writes it into instruction memory at consecutive word addresses.
- Counterpart of the opcode decoder: it produces the opcodes (LDUR, STUR, ADD, ADDI, SUB, AND, ORR, CBZ, CBNZ, B, HALT) that the decoder consumes.
- Used by the program loader and by test benches to fill instruction memory.

Parameters:
- ADDR_W, 8, instruction memory byte-address width.
- BASE_ADDR, 0, byte address of the first word written after start.
- ADDR_STEP, 4, byte increment per written word.
- MAX_ADDR, 252, byte address of the last writable word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begin a new program at BASE_ADDR.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request.
- op_sel  input  4  0 LDUR, 1 STUR, 2 ADD, 3 ADDI, 4 SUB, 5 AND, 6 ORR, 7 CBZ, 8 CBNZ, 9 B, 10 HALT; 11-15 illegal.
- rd  input  5  Rd/Rt field.
- rn  input  5  Rn field.
- rm  input  5  Rm field.
- imm  input  26  immediate, two's complement except ADDI (unsigned).
- mem_we  output  1  write request, held until acknowledged.
- mem_ack  input  1  memory accepted the write this cycle.
- mem_addr  output  ADDR_W  write byte address.
- mem_wdata  output  32  encoded word.
- err  output  1  one-cycle pulse: request rejected.
- err_count  output  8  rejected-request count, saturating at 255.
- done  output  1  program complete.
- overflow  output  1  memory filled before HALT.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on `reset`.
- Reset values:
  - state IDLE.
  - in_ready, mem_we, err, done, overflow = 0.
  - mem_addr = BASE_ADDR; mem_wdata = 0; err_count = 0.
- States: IDLE, ACCEPT, WRITE, PAD (optional feature only), DONE.
- IDLE/DONE + start -> ACCEPT:
  - mem_addr = BASE_ADDR.
  - done, overflow and err_count cleared.
- ACCEPT:
  - in_ready = 1.
  - A transfer occurs when in_valid && in_ready.
  - Legal request: word registered into mem_wdata, go to WRITE; mem_we = 1 on the next cycle.
- Encoding:
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): opcode[31:21], rm[20:16], shamt[15:10] = 0, rn[9:5], rd[4:0].
  - ADDI: 1001000100 in [31:22], imm[11:0] in [21:10], rn, rd.
  - LDUR 11111000010 / STUR 11111000000: opcode[31:21], imm[8:0] in [20:12], [11:10] = 00, rn, rd.
  - CBZ 10110100 / CBNZ 10110101: opcode[31:24], imm[18:0] in [23:5], rd[4:0].
  - B: 000101 in [31:26], imm[25:0] in [25:0].
  - HALT: [31:21] all ones, [20:0] = 0.
- Illegal requests (rejected):
  - op_sel > 10.
  - ADDI with imm > 4095.
  - LDUR/STUR with imm outside -256..255.
  - CBZ/CBNZ with imm outside -2^18..2^18-1.
  - Response: no write; err pulses the next cycle; err_count increments unless already 255; state stays ACCEPT.
- WRITE:
  - in_ready = 0; mem_we, mem_addr and mem_wdata held stable until mem_ack = 1.
  - On the ack cycle, mem_we drops the next cycle.
  - Word was HALT: go to DONE (or PAD), done = 1, mem_addr unchanged.
  - mem_addr == MAX_ADDR and word not HALT: overflow = 1, done = 1, go to DONE.
  - Otherwise: mem_addr += ADDR_STEP, return to ACCEPT.
- Throughput: one word per 2 cycles minimum (accept cycle + ack cycle).
- start while in ACCEPT or WRITE: ignored.
- reset mid-WRITE: mem_we drops on the next edge; partial program abandoned.
- B immediate always fits in 26 bits; never rejected.

Optional Feature:
- Macro: ENC_NOP_PAD_EN.
- Defined: after HALT is acknowledged, enter PAD; write 32'h00000000 at each following address up to MAX_ADDR, using the same mem_we/mem_ack rule. Then go to DONE with done = 1, overflow = 0. HALT at MAX_ADDR skips PAD.
- Undefined: no PAD state; HALT goes directly to DONE.

Test Plan:
- reset, start, ADD rd=1 rn=2 rm=3, mem_ack next cycle -> mem_addr 0, mem_wdata 32'h8B030041, then mem_addr 4.
- LDUR rd=5 rn=6 imm=-8 then STUR rd=5 rn=6 imm=16 -> 32'hF85F80C5 @0, 32'hF80100C5 @4.
- ADDI imm=5000, then op_sel=13 -> two err pulses, err_count 2, no mem_we, in_ready stays 1.
- CBZ rd=9 imm=-2, B imm=3, HALT, with mem_ack delayed 3 cycles each -> B4FFFFC9, 14000003, FFE00000; mem_we/addr/data stable while waiting; done = 1.
- MAX_ADDR=8 build, four ADDs -> three writes (0, 4, 8), overflow = 1, done = 1, fourth request never accepted.
- ENC_NOP_PAD_EN, MAX_ADDR=12, HALT at 0 -> zero words at 4, 8, 12, then done = 1, overflow = 0.
